if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 4: fetch-queue entries; allowed values 2, 4 or 8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 redirect_valid  input  1  branch/jump resolved; flush and refetch.
REQ-006 redirect_pc  input  32  new fetch address when redirect_valid=1; bits [1:0] ignored and forced to 0.
REQ-007 imem_req  output  1  instruction-memory request.
REQ-008 imem_addr  output  32  word-aligned fetch address, registered.
REQ-009 imem_ack  input  1  memory returns data this cycle; may be asserted in the same cycle imem_req rises.
REQ-010 imem_rdata  input  32  instruction word, valid only when imem_ack=1.
REQ-011 out_valid  output  1  queue head holds a valid pc/inst pair for the IF/ID register.
REQ-012 out_pc  output  32  address of the head instruction.
REQ-013 out_inst  output  32  head instruction word.
REQ-014 out_ready  input  1  IF/ID accepts the head; deasserted on pipeline stall.

Function
REQ-015 Internal state: fetch PC fpc, FIFO of DEPTH {pc,inst} entries, head/tail pointers, occupancy count (0..DEPTH), FSM {IDLE, REQ, DROP}.
REQ-016 imem_addr shall equal fpc at all times; imem_req shall be 1 exactly in states REQ and DROP.
REQ-017 At most one memory request is outstanding; while imem_req=1 and imem_ack=0, imem_addr shall be held stable.
REQ-018 IDLE: if count<DEPTH after this cycle's pop, go to REQ next cycle; otherwise stay IDLE.
REQ-019 REQ with imem_ack=1: write {fpc, imem_rdata} at tail, fpc<=fpc+4; go to REQ if the resulting count<DEPTH, else IDLE. This gives back-to-back fetch (one word per cycle) when imem_ack is tied high.
REQ-020 REQ with imem_ack=0: stay in REQ.
REQ-021 Pop: when out_valid=1 and out_ready=1, advance head and decrement count.
REQ-022 A simultaneous push and pop shall leave count unchanged; a push is never refused, because REQ is entered only with a free slot.
REQ-023 out_valid = (count!=0), and out_pc/out_inst are driven from the head entry.
REQ-024 Data written on ack cycle N shall be visible at the outputs in cycle N+1 when the queue was empty.
REQ-025 Redirect has priority over push and pop: count<=0, head=tail, fpc<=redirect_pc; out_valid=0 from the next cycle; the pop in the redirect cycle is ignored.
REQ-026 Redirect in REQ with imem_ack=0: go to DROP, keeping imem_addr at the old fpc until ack; fpc takes redirect_pc only on leaving DROP, while the redirect target is held in a shadow register.
REQ-027 Redirect in REQ with imem_ack=1: discard the returned word and go to REQ at redirect_pc.
REQ-028 DROP with imem_ack=1: discard data, load fpc from the shadow register, and go to REQ.
REQ-029 Redirect while in DROP: overwrite the shadow register and stay in DROP.
REQ-030 Redirect in IDLE: load fpc and go to REQ.
REQ-031 fpc arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-032 Pointers wrap modulo DEPTH.

Reset
REQ-033 rst=0 shall immediately force: FSM=IDLE, fpc=RESET_PC, count=0, pointers=0, all FIFO entries=0, imem_req=0, imem_addr=RESET_PC, out_valid=0, out_pc=0, out_inst=0.
REQ-034 Reset asserted mid-request shall abandon the request without waiting for ack; any later ack in IDLE is ignored.
REQ-035 The first imem_req=1 shall occur in the first clock cycle after rst deasserts.

Verification
REQ-036 imem_ack tied 1, out_ready=1, memory returns addr^32'hA5A5_0000: out_pc=0,4,8,... on consecutive cycles with matching out_inst; out_valid first high 2 cycles after reset release.
REQ-037 out_ready=0, DEPTH=4, ack always 1: exactly 4 words fetched (pcs 0..C), then imem_req=0 and count=4; raising out_ready pops pc 0 first and fetch resumes at 0x10.
REQ-038 Redirect to 0x0000_0103 while the queue holds 3 entries: out_valid=0 next cycle, next imem_addr=0x100, next out_pc=0x100.
REQ-039 Ack latency 3 cycles, redirect to 0x200 in the 1st wait cycle: imem_addr stays at the old pc until ack, that data is dropped, the next request is at 0x200, and no stale pc appears on out_pc.
REQ-040 RESET_PC=32'hFFFF_FFF8, ack=1: out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-041 rst asserted with ack pending and 2 entries queued: imem_req=0, out_valid=0, imem_addr=RESET_PC asynchronously; fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/if_fetch_if.sv
// Fetch-unit bus bundle: redirect input, instruction-memory handshake and
// the IF/ID output handshake. The fetch unit uses the master modport, the
// surrounding memory/pipeline environment uses the slave modport.
interface if_fetch_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_ready;

   modport master (
      input  redirect_valid, redirect_pc, imem_ack, imem_rdata, out_ready,
      output imem_req, imem_addr, out_valid, out_pc, out_inst
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_ack, imem_rdata, out_ready,
      input  imem_req, imem_addr, out_valid, out_pc, out_inst
   );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: keeps one memory request in flight, buffers
// returned {pc, inst} pairs in a small queue for the IF/ID register and
// handles redirects, including a redirect that lands while a request is
// still waiting for its ack (the late word is dropped, target parked in a
// shadow register).
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4            // 2, 4 or 8
) (
   input logic        clk,
   input logic        rst,                        // asynchronous, active-low
   if_fetch_if.master bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [31:0]        fpc_reg, fpc_next;
   logic [31:0]        shadow_reg, shadow_next;
   logic [PTR_W-1:0]   head_reg, head_next;
   logic [PTR_W-1:0]   tail_reg, tail_next;
   logic [CNT_W-1:0]   count_reg, count_next;

   logic [DEPTH-1:0][31:0] pc_flat;
   logic [DEPTH-1:0][31:0] inst_flat;

   logic               redirect;
   logic               push;
   logic               pop;
   logic [31:0]        redirect_target;
   logic [CNT_W-1:0]   count_after_pop;
   logic [CNT_W-1:0]   count_after_push;

   // Redirect wins over both queue operations; a push only happens on an
   // ack in REQ, which is entered only when a slot is free.
   assign redirect         = bus.redirect_valid;
   assign redirect_target  = bus.redirect_pc & 32'hFFFF_FFFC;
   assign push             = (state_reg == REQ) && bus.imem_ack && !redirect;
   assign pop              = (count_reg != '0) && bus.out_ready && !redirect;
   assign count_after_pop  = count_reg - CNT_W'(pop);
   assign count_after_push = count_after_pop + CNT_W'(push);

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next-state: issue requests while space remains, park in DROP when
   // a redirect arrives before the outstanding ack.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (redirect || (count_after_pop < DEPTH_C)) begin
               state_next = REQ;
            end
         end
         REQ: begin
            if (redirect) begin
               state_next = bus.imem_ack ? REQ : DROP;
            end else if (bus.imem_ack) begin
               state_next = (count_after_push < DEPTH_C) ? REQ : IDLE;
            end
         end
         DROP: begin
            if (bus.imem_ack) begin
               state_next = REQ;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: request while REQ/DROP; address is always the fetch PC so
   // it cannot move while a request waits for its ack.
   always_comb begin
      bus.imem_req  = (state_reg == REQ) || (state_reg == DROP);
      bus.imem_addr = fpc_reg;
      bus.out_valid = (count_reg != '0);
      bus.out_pc    = pc_flat[head_reg];
      bus.out_inst  = inst_flat[head_reg];
   end

   // Next fetch PC, shadow target, queue pointers and occupancy.
   always_comb begin
      fpc_next    = fpc_reg;
      shadow_next = shadow_reg;
      head_next   = head_reg;
      tail_next   = tail_reg;
      count_next  = count_reg;
      if (redirect) begin
         count_next = '0;
         head_next  = tail_reg;
         // An unacked request keeps its address; the target waits aside.
         if ((state_reg == REQ || state_reg == DROP) && !bus.imem_ack) begin
            shadow_next = redirect_target;
         end else begin
            fpc_next = redirect_target;
         end
      end else begin
         count_next = count_after_push;
         if (push) begin
            tail_next = tail_reg + PTR_W'(1);
            fpc_next  = fpc_reg + 32'd4;
         end
         if (pop) begin
            head_next = head_reg + PTR_W'(1);
         end
         if (state_reg == DROP && bus.imem_ack) begin
            fpc_next = shadow_reg;
         end
      end
   end

   // Fetch PC, shadow target, pointers and occupancy registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fpc_reg    <= RESET_PC;
         shadow_reg <= '0;
         head_reg   <= '0;
         tail_reg   <= '0;
         count_reg  <= '0;
      end else begin
         fpc_reg    <= fpc_next;
         shadow_reg <= shadow_next;
         head_reg   <= head_next;
         tail_reg   <= tail_next;
         count_reg  <= count_next;
      end
   end

   // Queue storage: one register pair per entry, cleared by reset so the
   // outputs read zero while the queue is empty after reset.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [31:0] pc_reg;
      logic [31:0] inst_reg;

      // Capture the returned word when this entry is the tail.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            pc_reg   <= '0;
            inst_reg <= '0;
         end else if (push && (tail_reg == PTR_W'(gi))) begin
            pc_reg   <= fpc_reg;
            inst_reg <= bus.imem_rdata;
         end
      end

      assign pc_flat[gi]   = pc_reg;
      assign inst_flat[gi] = inst_reg;
   end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a memory model answers with
// addr ^ 32'hA5A5_0000, expected {pc, inst} pairs go into a queue as the
// scenario is set up and are compared as the fetch stage presents them.
module tb_if_fetch;
   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic clk;
   logic rst;
   logic ack_level;
   logic lat_mode;
   int   wait_cnt;
   int   errors;
   int   checks;
   logic [31:0] exp_q[$];
   logic [31:0] pc;
   int   n;

   if_fetch_if bus ();
   if_fetch_if bus_w ();

   if_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   if_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_w (
      .clk (clk),
      .rst (rst),
      .bus (bus_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: either a fixed ack level or an ack after 3 wait cycles.
   always @(posedge clk) begin
      if (!rst || !bus.imem_req || bus.imem_ack) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
   end
   assign bus.imem_ack   = lat_mode ? (bus.imem_req && wait_cnt == 3) : ack_level;
   assign bus.imem_rdata = bus.imem_addr ^ KEY;

   assign bus_w.imem_ack       = 1'b1;
   assign bus_w.imem_rdata     = bus_w.imem_addr ^ KEY;
   assign bus_w.out_ready      = 1'b1;
   assign bus_w.redirect_valid = 1'b0;
   assign bus_w.redirect_pc    = 32'h0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1 rst = 1'b0;
      #1;
      checks++;
      if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h0)
         begin errors++; $display("FAIL reset_ctrl: req=%b valid=%b addr=%h, want 0 0 00000000", bus.imem_req, bus.out_valid, bus.imem_addr); end
      checks++;
      if (bus.out_pc !== 32'h0 || bus.out_inst !== 32'h0)
         begin errors++; $display("FAIL reset_out: pc=%h inst=%h, want 0 0", bus.out_pc, bus.out_inst); end
      checks++;
      if (bus_w.imem_addr !== 32'hFFFF_FFF8 || bus_w.imem_req !== 1'b0)
         begin errors++; $display("FAIL reset_pc_param: addr=%h req=%b, want FFFFFFF8 0", bus_w.imem_addr, bus_w.imem_req); end
      $display("test_reset done");
   endtask

   task automatic test_stream();
      exp_q.delete();
      ack_level = 1'b1; lat_mode = 1'b0; bus.out_ready = 1'b1; bus.redirect_valid = 1'b0;
      do_reset();
      tick();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0)
         begin errors++; $display("FAIL first_req: req=%b addr=%h, want 1 00000000", bus.imem_req, bus.imem_addr); end
      checks++;
      if (bus.out_valid !== 1'b0)
         begin errors++; $display("FAIL early_valid: valid=%b, want 0", bus.out_valid); end
      tick();
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
      for (int i = 0; i < 8; i++) begin
         pc = exp_q.pop_front();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== pc || bus.out_inst !== (pc ^ KEY))
            begin errors++; $display("FAIL stream[%0d]: valid=%b pc=%h inst=%h, want 1 %h %h", i, bus.out_valid, bus.out_pc, bus.out_inst, pc, pc ^ KEY); end
         $display("stream pc=%h inst=%h", bus.out_pc, bus.out_inst);
         tick();
      end
   endtask

   task automatic test_full();
      exp_q.delete();
      ack_level = 1'b1; lat_mode = 1'b0; bus.out_ready = 1'b0; bus.redirect_valid = 1'b0;
      do_reset();
      repeat (8) tick();
      checks++;
      if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h10)
         begin errors++; $display("FAIL full_stop: req=%b addr=%h, want 0 00000010", bus.imem_req, bus.imem_addr); end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_inst !== KEY)
         begin errors++; $display("FAIL full_head: valid=%b pc=%h inst=%h, want 1 0 %h", bus.out_valid, bus.out_pc, bus.out_inst, KEY); end
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
      bus.out_ready = 1'b1;
      pc = exp_q.pop_front();
      checks++;
      if (bus.out_pc !== pc)
         begin errors++; $display("FAIL full_first_pop: pc=%h, want %h", bus.out_pc, pc); end
      tick();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10)
         begin errors++; $display("FAIL full_resume: req=%b addr=%h, want 1 00000010", bus.imem_req, bus.imem_addr); end
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         if (bus.out_valid === 1'b1) begin
            pc = exp_q.pop_front();
            checks++;
            if (bus.out_pc !== pc || bus.out_inst !== (pc ^ KEY))
               begin errors++; $display("FAIL full_drain: pc=%h inst=%h, want %h %h", bus.out_pc, bus.out_inst, pc, pc ^ KEY); end
            $display("full pc=%h", bus.out_pc);
         end
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0)
         begin errors++; $display("FAIL full_timeout: %0d entries left, want 0", exp_q.size()); end
   endtask

   task automatic test_redirect();
      exp_q.delete();
      ack_level = 1'b1; lat_mode = 1'b0; bus.out_ready = 1'b0; bus.redirect_valid = 1'b0;
      do_reset();
      repeat (4) tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0)
         begin errors++; $display("FAIL redir_pre: valid=%b pc=%h, want 1 0", bus.out_valid, bus.out_pc); end
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0103; bus.out_ready = 1'b1;
      tick();
      bus.redirect_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h100 || bus.imem_req !== 1'b1)
         begin errors++; $display("FAIL redir_flush: valid=%b addr=%h req=%b, want 0 00000100 1", bus.out_valid, bus.imem_addr, bus.imem_req); end
      exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
      n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         if (bus.out_valid === 1'b1) begin
            pc = exp_q.pop_front();
            checks++;
            if (bus.out_pc !== pc || bus.out_inst !== (pc ^ KEY))
               begin errors++; $display("FAIL redir_drain: pc=%h inst=%h, want %h %h", bus.out_pc, bus.out_inst, pc, pc ^ KEY); end
            $display("redirect pc=%h", bus.out_pc);
         end
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0)
         begin errors++; $display("FAIL redir_timeout: %0d entries left, want 0", exp_q.size()); end
   endtask

   task automatic test_drop();
      exp_q.delete();
      ack_level = 1'b0; lat_mode = 1'b1; bus.out_ready = 1'b1; bus.redirect_valid = 1'b0;
      exp_q.push_back(32'h0);
      do_reset();
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 20) begin tick(); n++; end
      pc = exp_q.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== pc)
         begin errors++; $display("FAIL drop_first: valid=%b pc=%h, want 1 %h", bus.out_valid, bus.out_pc, pc); end
      tick();
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200;
      tick();
      bus.redirect_valid = 1'b0;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || bus.out_valid !== 1'b0)
         begin errors++; $display("FAIL drop_hold: req=%b addr=%h valid=%b, want 1 00000004 0", bus.imem_req, bus.imem_addr, bus.out_valid); end
      n = 0;
      while (bus.imem_ack !== 1'b1 && n < 10) begin
         checks++;
         if (bus.imem_addr !== 32'h4)
            begin errors++; $display("FAIL drop_addr_stable: addr=%h, want 00000004", bus.imem_addr); end
         tick();
         n++;
      end
      checks++;
      if (bus.imem_ack !== 1'b1 || bus.imem_addr !== 32'h4)
         begin errors++; $display("FAIL drop_ack: ack=%b addr=%h, want 1 00000004", bus.imem_ack, bus.imem_addr); end
      tick();
      checks++;
      if (bus.imem_addr !== 32'h200 || bus.imem_req !== 1'b1 || bus.out_valid !== 1'b0)
         begin errors++; $display("FAIL drop_target: addr=%h req=%b valid=%b, want 00000200 1 0", bus.imem_addr, bus.imem_req, bus.out_valid); end
      exp_q.push_back(32'h200); exp_q.push_back(32'h204);
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         if (bus.out_valid === 1'b1) begin
            pc = exp_q.pop_front();
            checks++;
            if (bus.out_pc !== pc || bus.out_inst !== (pc ^ KEY))
               begin errors++; $display("FAIL drop_drain: pc=%h inst=%h, want %h %h", bus.out_pc, bus.out_inst, pc, pc ^ KEY); end
            $display("drop pc=%h", bus.out_pc);
         end
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0)
         begin errors++; $display("FAIL drop_timeout: %0d entries left, want 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      exp_q.delete();
      ack_level = 1'b1; lat_mode = 1'b0; bus.out_ready = 1'b0; bus.redirect_valid = 1'b0;
      do_reset();
      repeat (3) tick();
      ack_level = 1'b0;
      repeat (2) tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8)
         begin errors++; $display("FAIL rmid_pre: valid=%b req=%b addr=%h, want 1 1 00000008", bus.out_valid, bus.imem_req, bus.imem_addr); end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h0)
         begin errors++; $display("FAIL rmid_async: req=%b valid=%b addr=%h, want 0 0 00000000", bus.imem_req, bus.out_valid, bus.imem_addr); end
      checks++;
      if (bus.out_pc !== 32'h0 || bus.out_inst !== 32'h0)
         begin errors++; $display("FAIL rmid_out: pc=%h inst=%h, want 0 0", bus.out_pc, bus.out_inst); end
      ack_level = 1'b1;
      tick();
      rst = 1'b1; bus.out_ready = 1'b1;
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0)
         begin errors++; $display("FAIL rmid_restart: valid=%b req=%b addr=%h, want 0 1 00000000", bus.out_valid, bus.imem_req, bus.imem_addr); end
      exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         if (bus.out_valid === 1'b1) begin
            pc = exp_q.pop_front();
            checks++;
            if (bus.out_pc !== pc || bus.out_inst !== (pc ^ KEY))
               begin errors++; $display("FAIL rmid_drain: pc=%h inst=%h, want %h %h", bus.out_pc, bus.out_inst, pc, pc ^ KEY); end
            $display("reset_mid pc=%h", bus.out_pc);
         end
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0)
         begin errors++; $display("FAIL rmid_timeout: %0d entries left, want 0", exp_q.size()); end
   endtask

   task automatic test_wrap();
      exp_q.delete();
      ack_level = 1'b1; lat_mode = 1'b0; bus.out_ready = 1'b1; bus.redirect_valid = 1'b0;
      do_reset();
      tick();
      tick();
      exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h0000_0004);
      for (int i = 0; i < 4; i++) begin
         pc = exp_q.pop_front();
         checks++;
         if (bus_w.out_valid !== 1'b1 || bus_w.out_pc !== pc || bus_w.out_inst !== (pc ^ KEY))
            begin errors++; $display("FAIL wrap[%0d]: valid=%b pc=%h inst=%h, want 1 %h %h", i, bus_w.out_valid, bus_w.out_pc, bus_w.out_inst, pc, pc ^ KEY); end
         $display("wrap pc=%h", bus_w.out_pc);
         tick();
      end
   endtask

   initial begin
      errors = 0; checks = 0;
      ack_level = 1'b0; lat_mode = 1'b0;
      bus.out_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
      test_reset();
      test_stream();
      test_full();
      test_redirect();
      test_drop();
      test_reset_mid();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, want finished");
      $fatal(1, "watchdog expired");
   end
endmodule
